serial_adder: RTL
=================

# serial_adder

Bit-serial ripple adder: adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first, using a single full-adder cell and a carry flop. It is the additive counterpart of the combinational full subtractor and sits in the arithmetic library as the area-minimal adder for multi-cycle datapaths. A start/busy/done handshake frames each operation, and the result is held until the next operation completes.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits (≥2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; sampled on the accepting edge
- b  input  WIDTH  operand B; sampled on the accepting edge
- cin  input  1  carry-in; sampled on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse in DONE
- sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH
- cout  output  1  registered carry-out of bit WIDTH-1

## Operation
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry flop and bit counter cleared. Asserting reset mid-operation discards the operation. Outputs stay at their reset values until a new operation completes.
- Registers:
  - A/B shift registers (WIDTH each), shifted right one bit per RUN cycle.
  - Result shift register (WIDTH), filled from the MSB end.
  - Carry flop.
  - Counter of width clog2(WIDTH).
- Full-adder cell, combinational on shift-register bit 0 and the carry flop:
  - s = a0 ^ b0 ^ c
  - co = a0&b0 | a0&c | b0&c
- FSM states:
  - IDLE: on an edge with start=1, load a, b; carry←cin; count←0; go to RUN. With start=0, stay.
  - RUN: each edge shifts s into the result MSB, sets carry←co, shifts A/B right and increments count. On the edge where count==WIDTH-1: sum←final result word, cout←co, go to DONE.
  - DONE: done=1 for exactly this cycle; next edge goes unconditionally to IDLE.
- start is ignored in RUN and DONE; no queuing. A start held high is re-accepted at the first IDLE edge.
- sum/cout change only on the RUN→DONE edge and hold until the next completion or reset.
- Operands may change freely after the accepting edge.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true bit WIDTH. For two's-complement overflow, the user compares carries externally. No overflow output is provided.

## Timing
- Accept edge E0 (IDLE, start=1).
- busy=1 from after E0 through E_WIDTH.
- sum/cout valid and done=1 in the cycle after E_WIDTH.
- Back to IDLE after E_WIDTH+1.
- Latency from start sampled to done high: WIDTH+1 edges.
- Minimum start-to-start spacing: WIDTH+2 cycles.
- busy and done are never both high. done is never high for two consecutive cycles.
- All outputs are registered; there are no combinational input→output paths.

## Test plan
- Reset values: hold rst_n=0 → busy=0, done=0, sum=0, cout=0. Release, keep start=0 for 20 cycles → outputs unchanged.
- Basic carry chain (WIDTH=8): a=8'hFF, b=8'h01, cin=0 → done exactly 9 edges after the accept edge, sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 → sum=8'h00, cout=1. Then a=8'h12, b=8'h34, cin=0 → sum=8'h46, cout=0.
- Start ignored while busy: pulse start with a=8'h01, b=8'h01 mid-RUN of an 8'h10+8'h20 operation → sum=8'h30, exactly one done pulse, and no second operation unless start is high in IDLE.
- Reset mid-operation: assert rst_n=0 four cycles into RUN → busy, done, sum and cout return to 0 immediately. A following 8'h0F+8'h01 completes with sum=8'h10, cout=0.
- Back-to-back with start held high: two operations with done pulses 10 cycles apart, sum updated at each, busy=0 in each DONE cycle.
- Random check: 1000 random a, b, cin at WIDTH=8 and WIDTH=16 compared against a reference a+b+cin → {cout,sum} matches on every done.

Source files
------------

// File: rtl/serial_adder_if.sv
// serial_adder handshake bundle
// requester drives start/operands, adder returns status/result
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start,
    output a,
    output b,
    output cin,
    input  busy,
    input  done,
    input  sum,
    input  cout
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  cin,
    output busy,
    output done,
    output sum,
    output cout
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, LSB first
// one full-adder cell plus a carry flop, start/busy/done framed
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             c_q;
  logic             c_d;
  logic             cout_q;
  logic             cout_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_nxt;

  // full-adder cell on the low bits of the shift registers
  always_comb begin
    fa_s    = a_q[0] ^ b_q[0] ^ c_q;
    fa_co   = (a_q[0] & b_q[0])
            | (a_q[0] & c_q)
            | (b_q[0] & c_q);
    res_nxt = {fa_s, res_q[WIDTH-1:1]};
  end

  // next-state: accept in IDLE, shift in RUN, pulse done in DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d  = res_nxt;
        c_d    = fa_co;
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        busy_d = 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = res_nxt;
          cout_d  = fa_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
